// File: rtl/fa_serial_nbit_if.sv
// Request/response bundle for the bit-serial adder: operands and start in,
// registered sum, carry and status out.
interface fa_serial_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output start_in, a_in, b_in, carry_in,
        input  sum_out, carry_out, busy_out, done_out
    );

    modport slave (
        input  start_in, a_in, b_in, carry_in,
        output sum_out, carry_out, busy_out, done_out
    );
endinterface

// File: rtl/fa_serial_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// one bit per clock, with a one-cycle done pulse when the result lands.
module fa_serial_nbit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module fa_serial_nbit #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    fa_serial_nbit_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_shift;

    fa_serial_nbit_cell u_cell (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (c_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_shift = {fa_s, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_in) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    c_d     = bus.carry_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ADD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_c;
                res_d = res_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum_out   = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
endmodule
